// File: rtl/acc_requant_stage.sv
// acc_requant_stage: accumulates signed MAC partial sums until a last-beat
// marker, then requantizes the total with a runtime scale and shift
// (round half up), saturates it to signed 8 bits and hands it downstream
// over a valid/ready handshake. Every output is driven straight from a flop.
module acc_requant_stage #(
  parameter int ACC_W   = 32,
  parameter int SUM_W   = 36,
  parameter int SCALE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic               in_last,
  input  logic [SCALE_W-1:0] scale,
  input  logic [4:0]         shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         data_out,
  output logic               out_sat
);

  localparam int PROD_W = SUM_W + SCALE_W + 1;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};
  localparam logic signed [PROD_W:0]  RES_MAX = (PROD_W+1)'(127);
  localparam logic signed [PROD_W:0]  RES_MIN = (PROD_W+1)'(-128);

  typedef enum logic [1:0] {ACC, MUL, RND, OUT} state_t;

  state_t                    r_state;
  state_t                    w_nextState;

  logic signed [SUM_W-1:0]   r_sum;
  logic signed [SUM_W-1:0]   r_total;
  logic [SCALE_W-1:0]        r_scale;
  logic [4:0]                r_shift;
  logic signed [PROD_W-1:0]  r_prod;
  logic                      r_inReady;
  logic                      r_outValid;
  logic                      r_outSat;
  logic [7:0]                r_dataOut;

  logic                      w_accept;
  logic signed [SUM_W:0]     w_sumWide;
  logic signed [SUM_W-1:0]   w_sumSat;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [PROD_W:0]    w_half;
  logic signed [PROD_W:0]    w_rounded;
  logic signed [PROD_W:0]    w_shifted;
  logic [7:0]                w_clamped;
  logic                      w_clampSat;

  assign w_accept  = in_valid && r_inReady;
  assign w_sumWide = {r_sum[SUM_W-1], r_sum}
                   + {{(SUM_W+1-ACC_W){acc_in[ACC_W-1]}}, acc_in};
  assign w_prod    = PROD_W'(r_total) * PROD_W'($signed({1'b0, r_scale}));
  assign w_rounded = {r_prod[PROD_W-1], r_prod} + w_half;
  assign w_shifted = w_rounded >>> r_shift;

  // Saturating accumulator add: one guard bit detects overflow, then pin to the rail
  always_comb begin
    w_sumSat = w_sumWide[SUM_W-1:0];
    if (w_sumWide[SUM_W] != w_sumWide[SUM_W-1]) begin
      w_sumSat = w_sumWide[SUM_W] ? SUM_MIN : SUM_MAX;
    end
  end

  // Rounding bias of half an LSB of the shifted result, none when shift is 0
  always_comb begin
    w_half = '0;
    if (r_shift != 5'd0) begin
      w_half = {{PROD_W{1'b0}}, 1'b1} << (r_shift - 5'd1);
    end
  end

  // Clamp the rounded result into signed 8 bits and flag any clipping
  always_comb begin
    w_clamped  = w_shifted[7:0];
    w_clampSat = 1'b0;
    if (w_shifted > RES_MAX) begin
      w_clamped  = 8'h7F;
      w_clampSat = 1'b1;
    end else if (w_shifted < RES_MIN) begin
      w_clamped  = 8'h80;
      w_clampSat = 1'b1;
    end
  end

  // Next-state logic: accumulate, multiply, round, then hold until taken
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ACC:     if (w_accept && in_last) w_nextState = MUL;
      MUL:     w_nextState = RND;
      RND:     w_nextState = OUT;
      OUT:     if (out_ready) w_nextState = ACC;
      default: w_nextState = ACC;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_nextState;
  end

  // Datapath and registered outputs; in_ready is precomputed from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= '0;
      r_total    <= '0;
      r_scale    <= '0;
      r_shift    <= '0;
      r_prod     <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_dataOut  <= '0;
      r_outSat   <= 1'b0;
    end else begin
      r_inReady <= (w_nextState == ACC);
      case (r_state)
        ACC: begin
          if (w_accept) begin
            if (in_last) begin
              r_total <= w_sumSat;
              r_scale <= scale;
              r_shift <= shift;
              r_sum   <= '0;
            end else begin
              r_sum   <= w_sumSat;
            end
          end
        end
        MUL: r_prod <= w_prod;
        RND: begin
          r_dataOut  <= w_clamped;
          r_outSat   <= w_clampSat;
          r_outValid <= 1'b1;
        end
        OUT: if (out_ready) r_outValid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign data_out  = r_dataOut;
  assign out_sat   = r_outSat;

endmodule
